// File: rtl/adder_share_arbiter.sv
// Round-robin front end for one shared adder: grant, one-cycle EXEC, registered response.
// Latency: handshake in T, resp_valid in T+2; no new grant until the response is accepted.
module adder_share_arbiter #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 32,
  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ*WIDTH-1:0] req_a,
  input  logic [N_REQ*WIDTH-1:0] req_b,
  input  logic [N_REQ-1:0]       req_cin,
  output logic [WIDTH-1:0]       add_a,
  output logic [WIDTH-1:0]       add_b,
  output logic                   add_cin,
  input  logic [WIDTH-1:0]       add_sum,
  input  logic                   add_cout,
  output logic [N_REQ-1:0]       resp_valid,
  input  logic [N_REQ-1:0]       resp_ready,
  output logic [WIDTH-1:0]       resp_sum,
  output logic                   resp_cout,
  output logic [IW-1:0]          resp_id,
  output logic                   busy,
  output logic [15:0]            op_count
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t        state, state_nxt;
  logic [IW-1:0] ptr;
  logic [IW-1:0] gnt_idx;
  logic          gnt_found;
  logic [IW:0]   cand;
  logic          grant;
  logic          done;

  // First valid requester scanning ptr, ptr+1, ... modulo N_REQ.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = {1'b0, ptr} + (IW+1)'(k);
      if (cand >= (IW+1)'(N_REQ)) cand = cand - (IW+1)'(N_REQ);
      if (!gnt_found && req_valid[cand[IW-1:0]]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand[IW-1:0];
      end
    end
  end

  assign grant = (state == IDLE) && gnt_found;
  assign done  = (state == RESP) && resp_ready[resp_id];

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (gnt_found) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (resp_ready[resp_id]) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Gated by rst_n so the grant strobe drops the instant reset is applied.
  always_comb begin
    req_ready  = '0;
    resp_valid = '0;
    if (grant && rst_n) req_ready = N_REQ'(1) << gnt_idx;
    if (state == RESP) resp_valid = N_REQ'(1) << resp_id;
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      add_a     <= '0;
      add_b     <= '0;
      add_cin   <= 1'b0;
      resp_sum  <= '0;
      resp_cout <= 1'b0;
      resp_id   <= '0;
      op_count  <= '0;
    end else begin
      state <= state_nxt;
      if (grant) begin
        add_a   <= req_a[gnt_idx*WIDTH +: WIDTH];
        add_b   <= req_b[gnt_idx*WIDTH +: WIDTH];
        add_cin <= req_cin[gnt_idx];
        resp_id <= gnt_idx;
        ptr     <= (gnt_idx == IW'(N_REQ-1)) ? '0 : gnt_idx + 1'b1;
      end
      if (state == EXEC) begin
        resp_sum  <= add_sum;
        resp_cout <= add_cout;
      end
      if (done) op_count <= op_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Directed bench for adder_share_arbiter; the shared adder is modelled behaviourally here.
module tb_adder_share_arbiter;
  localparam int N = 4;
  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req_valid, req_ready, req_cin, resp_valid, resp_ready;
  logic [N*W-1:0] req_a, req_b;
  logic [W-1:0]   add_a, add_b, add_sum, resp_sum;
  logic           add_cin, add_cout, resp_cout, busy;
  logic [1:0]     resp_id;
  logic [15:0]    op_count;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {{W{1'b0}}, add_cin};

  adder_share_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_cin(req_cin),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_sum(resp_sum), .resp_cout(resp_cout), .resp_id(resp_id),
    .busy(busy), .op_count(op_count)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
    req_cin[i]      = c;
  endtask

  initial begin
    rst_n = 1'b0; req_valid = '0; resp_ready = '0;
    req_a = '0; req_b = '0; req_cin = '0;
    #12;
    check("rst_ready", req_ready, 4'b0000);
    check("rst_rvalid", resp_valid, 4'b0000);
    check("rst_busy", busy, 1'b0);
    check("rst_count", op_count, 16'h0000);
    check("rst_add_a", add_a, 32'h0);

    // Single op on requester 2
    step();
    rst_n = 1'b1;
    resp_ready = 4'b1111;
    set_op(2, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0);
    req_valid = 4'b0100;
    #1 check("single_ready", req_ready, 4'b0100);
    step(); req_valid = '0;
    #1 check("single_exec_busy", busy, 1'b1);
    check("single_exec_ready", req_ready, 4'b0000);
    check("single_add_b", add_b, 32'hFFFF_FFFF);
    step();
    check("single_rvalid", resp_valid, 4'b0100);
    check("single_sum", resp_sum, 32'h0000_0000);
    check("single_cout", resp_cout, 1'b1);
    check("single_id", resp_id, 2'd2);
    step();
    check("single_count", op_count, 16'd1);
    check("single_idle", busy, 1'b0);

    // Fairness from a fresh reset: all four valid, resp_ready high
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < N; i++) set_op(i, 32'h10 * (i + 1), 32'h100 * (i + 1), 1'b0);
    req_valid = 4'b1111;
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      #1 check($sformatf("fair_grant%0d", k), req_ready, 4'b0001 << (k % 4));
      step();
      check($sformatf("fair_exec_ready%0d", k), req_ready, 4'b0000);
      step();
      check($sformatf("fair_id%0d", k), resp_id, k % 4);
      check($sformatf("fair_sum%0d", k), resp_sum, 32'h110 * ((k % 4) + 1));
      step();
    end
    check("fair_count", op_count, 16'd6);

    // Backpressure: requester 1, requester 0 shows up while busy
    req_valid = 4'b0010;
    resp_ready = '0;
    set_op(1, 32'h1234_5678, 32'h1111_1111, 1'b1);
    set_op(0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1);
    #1 check("bp_ready", req_ready, 4'b0010);
    step(); req_valid = 4'b0001;
    #1 check("bp_exec_ready", req_ready, 4'b0000);
    step();
    for (int c = 0; c < 5; c++) begin
      check($sformatf("bp_hold_valid%0d", c), resp_valid, 4'b0010);
      check($sformatf("bp_hold_sum%0d", c), resp_sum, 32'h2345_678A);
      check($sformatf("bp_no_grant%0d", c), req_ready, 4'b0000);
      step();
    end
    check("bp_cout", resp_cout, 1'b0);
    resp_ready = 4'b0010;
    step();
    check("bp_count", op_count, 16'd7);
    #1 check("bp_next_grant", req_ready, 4'b0001);
    resp_ready = 4'b0001;
    step(); req_valid = '0;
    step();
    check("bp_r0_sum", resp_sum, 32'h0000_0001);
    check("bp_r0_cout", resp_cout, 1'b1);
    check("bp_r0_id", resp_id, 2'd0);
    step();
    check("bp_r0_count", op_count, 16'd8);

    // Response for id 3 with only resp_ready[0] asserted
    set_op(3, 32'd5, 32'd6, 1'b0);
    req_valid = 4'b1000;
    #1 check("wp_ready", req_ready, 4'b1000);
    step(); req_valid = '0;
    step();
    for (int c = 0; c < 3; c++) begin
      check($sformatf("wp_hold%0d", c), resp_valid, 4'b1000);
      check($sformatf("wp_count%0d", c), op_count, 16'd8);
      step();
    end
    check("wp_sum", resp_sum, 32'd11);
    resp_ready = 4'b1000;
    step();
    check("wp_done_count", op_count, 16'd9);
    check("wp_done_busy", busy, 1'b0);

    // Reset during EXEC
    resp_ready = 4'b1111;
    set_op(1, 32'hAAAA_0000, 32'h0000_5555, 1'b0);
    req_valid = 4'b0100;
    step(); req_valid = 4'b1010;
    #1 check("mid_exec_busy", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check("mid_busy", busy, 1'b0);
    check("mid_ready", req_ready, 4'b0000);
    check("mid_rvalid", resp_valid, 4'b0000);
    check("mid_add_a", add_a, 32'h0);
    check("mid_count", op_count, 16'd0);
    rst_n = 1'b1;
    #1 check("mid_first_grant", req_ready, 4'b0010);
    step(); req_valid = '0;
    step();
    check("mid_sum", resp_sum, 32'hAAAA_5555);
    step();
    check("mid_op_count", op_count, 16'd1);

    // op_count wrap
    force dut.op_count = 16'hFFFF;
    #1 release dut.op_count;
    #1 check("wrap_pre", op_count, 16'hFFFF);
    req_valid = 4'b0001;
    step(); req_valid = '0;
    step();
    check("wrap_rvalid", resp_valid, 4'b0001);
    step();
    check("wrap_count", op_count, 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/adder_share_arbiter.md
# adder_share_arbiter

Round-robin arbiter and sequencer that shares the single 32-bit Ladner-Fischer adder between up to four requesters. Each requester presents operands with a valid/ready handshake. The block latches the granted operands, drives the adder for one cycle, registers sum and carry, and returns the result to the winning requester. It sits between the per-port input controllers and the shared adder instance, and also keeps a count of completed operations.

## Interface
- N_REQ, 4, number of requesters (2..8); index width IW = clog2(N_REQ), minimum 1
- WIDTH, 32, operand and sum width
- clk  in  1  single clock; all state changes on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  N_REQ  per-requester operand valid
- req_ready  out  N_REQ  one-hot grant/accept strobe
- req_a  in  N_REQ*WIDTH  operand A; requester i occupies bits [i*WIDTH +: WIDTH]
- req_b  in  N_REQ*WIDTH  operand B, same packing
- req_cin  in  N_REQ  carry-in per requester
- add_a, add_b  out  WIDTH  registered operands to the shared adder
- add_cin  out  1  registered carry-in to the adder
- add_sum  in  WIDTH  adder sum (combinational from add_a/add_b/add_cin)
- add_cout  in  1  adder carry-out
- resp_valid  out  N_REQ  one-hot: result available for requester i
- resp_ready  in  N_REQ  requester i consumes the result
- resp_sum  out  WIDTH  registered sum
- resp_cout  out  1  registered carry-out
- resp_id  out  IW  index of the requester that owns the result
- busy  out  1  high whenever state is not IDLE
- op_count  out  16  completed operations, wraps 0xFFFF -> 0x0000

## Operation
- The FSM has three states:
  - IDLE: if any req_valid is set, grant exactly one requester, chosen round-robin starting at pointer ptr. req_ready[g] is combinational and is high only in IDLE. On that edge, latch req_a/req_b/req_cin of g into add_a/add_b/add_cin, latch resp_id = g, set ptr = (g+1) mod N_REQ, and go to EXEC.
  - EXEC: the adder settles for one full cycle. On that edge, latch add_sum/add_cout into resp_sum/resp_cout and go to RESP.
  - RESP: resp_valid[resp_id] is high. When resp_ready[resp_id] is high, increment op_count and go to IDLE. resp_ready bits for other indices are ignored.
- Round-robin search order is ptr, ptr+1, …, ptr+N_REQ-1 (mod N_REQ). The first valid requester in that order wins.
- A requester must hold req_valid and its operands stable until req_ready. Deasserting req_valid before grant withdraws the request with no side effects.
- No new grant is issued while busy. req_ready is all-zero in EXEC and RESP regardless of req_valid.
- add_a/add_b/add_cin hold their last values outside EXEC. resp_sum/resp_cout hold until the next EXEC.
- Arithmetic is modulo 2^WIDTH. Carry-out comes only from the adder. The block does no arithmetic besides ptr and op_count.

## Timing
- Reset (asynchronous, rst_n=0) sets:
  - state = IDLE, ptr = 0
  - add_a, add_b, add_cin, resp_sum, resp_cout, resp_id, op_count = 0
  - resp_valid, req_ready, busy = 0
- Reset takes effect immediately, mid-operation included. In-flight operands and results are discarded and op_count is not incremented.
- Handshake at cycle T (req_valid[i] & req_ready[i]) leads to EXEC in cycle T+1 and resp_valid[i] in cycle T+2.
- If resp_ready[i] is high in T+2, the next grant can occur in cycle T+3. Peak throughput is one operation per 3 cycles. Added latency equals the number of cycles resp_ready stays low.
- resp_valid, resp_sum, resp_cout and resp_id are stable for the whole RESP period.
- Simultaneous requests are served in round-robin order. With all N_REQ valid continuously from reset, the grant order is 0,1,2,3,0,…
- A new req_valid arriving during RESP is evaluated in the first IDLE cycle after the response completes.
- op_count increments exactly on the RESP→IDLE edge.

## Test plan
- Single op: reset, req 2 with a=0x0000_0001, b=0xFFFF_FFFF, cin=0. Expect req_ready[2] in T, resp_valid=0b0100 in T+2, resp_sum=0x0000_0000, resp_cout=1, resp_id=2, op_count=1.
- Fairness: all 4 valid continuously, resp_ready tied high. Expect grants 0,1,2,3,0,1 at cycles 0,3,6,9,12,15, and op_count=6 after 18 cycles.
- Backpressure: req 1 a=0x1234_5678, b=0x1111_1111, cin=1, with resp_ready[1] low for 5 cycles. Expect resp_valid[1] held with resp_sum=0x2345_678A; no grant to req 0 (valid) until after acceptance.
- Wrong-port ready: in RESP for id 3, assert resp_ready[0] only. Expect the state to stay in RESP and op_count unchanged.
- Reset mid-op: assert rst_n=0 during EXEC. Expect all outputs 0 immediately, op_count=0, and the first grant after reset to go to the lowest valid index.
- Wrap: preload op_count to 0xFFFF via 65535 ops (or force). On the next completion expect 0x0000.
